countdown_sprite_ctrl: RTL
==========================

# countdown_sprite_ctrl

Pre-game countdown overlay controller for the VGA path. It sequences the digits 3, 2 and 1, each shown for a fixed number of frames. For every active pixel inside a 20x20 on-screen window, it generates the digit-ROM address (0..399). It then re-aligns the ROM's registered 8-bit output into a pixel stream with a draw-enable. It sits directly upstream of the 20x20 number ROMs (address 10 bits, 1-cycle registered read) and feeds the colour mux ahead of the VGA output registers.

## Interface
- X0, 310, left column of sprite window; X0+19 must not exceed 1023
- Y0, 230, top row of sprite window; Y0+19 must not exceed 1023
- FRAMES_PER_DIGIT, 60, i_frame_tick pulses each digit stays on screen (≥1)
- KEY, 8'h00, transparent pixel value; never drawn
- i_clk2  in  1  pixel clock; the only clock
- i_rst  in  1  synchronous, active-high reset
- i_x  in  10  current pixel column
- i_y  in  10  current pixel row
- i_active  in  1  video-active flag for (i_x, i_y)
- i_frame_tick  in  1  one-cycle pulse per frame, asserted only during vertical blanking
- i_start  in  1  one-cycle request to begin the countdown
- i_romdata  in  8  selected digit-ROM output, 1 cycle after o_numberaddr
- o_numberaddr  out  10  registered ROM address
- o_digit  out  2  registered ROM select: 3, 2, 1; 0 when idle
- o_pix  out  8  registered pixel value
- o_pix_en  out  1  registered: o_pix is to be drawn
- o_busy  out  1  countdown in progress
- o_done  out  1  one-cycle pulse when the countdown ends

## Operation
- States:
  - IDLE: o_digit=0, o_busy=0
  - SHOW3, SHOW2, SHOW1: o_digit=3/2/1, o_busy=1
  - DONE: o_done=1, lasts one cycle, then IDLE
- Transitions:
  - IDLE + i_start → SHOW3, with the frame counter cleared.
  - In a SHOW state, each i_frame_tick increments the frame counter. The tick that brings the count to FRAMES_PER_DIGIT advances to the next state (SHOW3→SHOW2→SHOW1→DONE) and clears the counter.
  - i_start outside IDLE is ignored; no restart.
  - i_frame_tick in IDLE or DONE is ignored.
- Frame counter width is clog2(FRAMES_PER_DIGIT+1) bits; the counter never wraps past FRAMES_PER_DIGIT.
- Window hit (stage 0) requires all of:
  - a SHOW state
  - i_active=1
  - (i_x−X0) < 20 and (i_y−Y0) < 20, computed as 10-bit unsigned subtraction, so coordinates left of or above the window wrap high and miss.
- Address:
  - On hit: o_numberaddr ← row*20 + col, where row=i_y−Y0 and col=i_x−X0; the product is computed as (row<<4)+(row<<2). Maximum value is 399.
  - On miss: o_numberaddr ← 0.
- Hit flag is delayed two cycles alongside the ROM read.
- Output stage:
  - o_pix ← i_romdata.
  - o_pix_en ← delayed hit AND (i_romdata != KEY).
  - When o_pix_en=0, o_pix is still loaded but is don't-care to consumers.
- o_digit changes only on i_frame_tick, which falls in blanking, or on reset. No mid-frame digit switch is possible.
- Reset (any state, including mid-countdown): next state IDLE, counter 0, pipeline flags cleared. Reset wins over simultaneous i_start or i_frame_tick.

## Timing
- Reset values:
  - o_numberaddr=0, o_digit=0, o_pix=0
  - o_pix_en=0, o_busy=0, o_done=0
- i_start sampled at edge k: o_busy=1 and o_digit=3 from after edge k.
- Address latency: coordinates sampled at edge k; o_numberaddr valid after edge k.
- ROM: samples the address at edge k+1; i_romdata valid after edge k+1.
- Pixel latency: o_pix/o_pix_en valid after edge k+2, i.e. 3 cycles from coordinate presentation to pixel. Consumers delay hsync/vsync/active by the same 3 cycles.
- Throughput: one pixel per clock, no stalls.
- Final SHOW1 tick at edge k:
  - DONE after edge k, with o_done=1 and o_busy=0 for that one cycle.
  - IDLE after edge k+1.
- Pixels already in flight when the state leaves SHOW1 still emerge; this is harmless because state change occurs in blanking.

## Test plan
- Reset mid-SHOW2 with i_start held high the same cycle:
  - All outputs are 0 the next cycle; state is IDLE.
  - No restart until a fresh i_start after reset deasserts.
- FRAMES_PER_DIGIT=2, start then 6 frame ticks:
  - o_digit steps 3,3,2,2,1,1 (3→2 after tick 2, 2→1 after tick 4, 1→0 after tick 6).
  - o_done pulses once, one cycle after tick 6; o_busy then drops.
- Address mapping in SHOW3:
  - (x,y)=(310,230) → o_numberaddr 0.
  - (329,230) → 19.
  - (310,231) → 20.
  - (329,249) → 399.
  - (309,230), (330,230), (310,250) → 0, and hit=0 three cycles later.
- ROM model returning 8'hAB with 1-cycle latency, in-window pixel: o_pix=AB, o_pix_en=1 exactly 3 cycles after the coordinate. With ROM returning KEY=00: o_pix_en=0.
- i_active=0 inside the window, or state IDLE: o_pix_en stays 0 across a full scanned frame.
- i_start pulsed again during SHOW2: no effect; sequence and counter timing are unchanged.

Source files
------------

// File: rtl/countdown_sprite_ctrl_if.sv
// Bus bundle between the VGA timing/ROM side (master) and the countdown
// sprite controller (slave).
//
// Transfer rule: the stream has no backpressure. Every clock the master
// presents one pixel coordinate (i_x, i_y, i_active). Exactly three clocks
// later the slave presents the matching o_pix, and o_pix_en qualifies it.
// o_pix_en=1 means "draw o_pix"; o_pix_en=0 means o_pix is don't-care.
// i_romdata must be the ROM word for the o_numberaddr of the previous clock.
// o_state is a debug view of the sequencer: 0 IDLE, 1 SHOW3, 2 SHOW2,
// 3 SHOW1, 4 DONE.
interface countdown_sprite_ctrl_if;
    logic [9:0] i_x;
    logic [9:0] i_y;
    logic       i_active;
    logic       i_frame_tick;
    logic       i_start;
    logic [7:0] i_romdata;
    logic [9:0] o_numberaddr;
    logic [1:0] o_digit;
    logic [7:0] o_pix;
    logic       o_pix_en;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_state;

    modport master (
        output i_x, i_y, i_active, i_frame_tick, i_start, i_romdata,
        input  o_numberaddr, o_digit, o_pix, o_pix_en, o_busy, o_done, o_state
    );

    modport slave (
        input  i_x, i_y, i_active, i_frame_tick, i_start, i_romdata,
        output o_numberaddr, o_digit, o_pix, o_pix_en, o_busy, o_done, o_state
    );
endinterface

// File: rtl/countdown_sprite_ctrl.sv
// Pre-game countdown overlay: shows digits 3, 2, 1 for FRAMES_PER_DIGIT
// frames each, generates the 20x20 digit-ROM address for pixels inside the
// sprite window and re-aligns the registered ROM word into a pixel stream.
// The window corner must keep X0+19 and Y0+19 within 10 bits.
module countdown_sprite_ctrl #(
    parameter int unsigned X0               = 310,
    parameter int unsigned Y0               = 230,
    parameter int unsigned FRAMES_PER_DIGIT = 60,
    parameter logic [7:0]  KEY              = 8'h00
) (
    input  logic                   i_clk2,
    input  logic                   i_rst,
    countdown_sprite_ctrl_if.slave bus
);
    localparam int unsigned CW     = $clog2(FRAMES_PER_DIGIT + 1);
    localparam logic [9:0]  X0_V   = 10'(X0);
    localparam logic [9:0]  Y0_V   = 10'(Y0);
    localparam logic [9:0]  SPR_SZ = 10'd20;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_DIGIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOW3 = 3'd1,
        ST_SHOW2 = 3'd2,
        ST_SHOW1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    digit_q;
    logic          busy_q;
    logic          done_q;

    logic [9:0] col_d;
    logic [9:0] row_d;
    logic       show_d;
    logic       hit_d;
    logic [9:0] addr_d;

    logic [9:0] addr_q;
    logic       hit1_q;
    logic       hit2_q;
    logic [7:0] pix_q;
    logic       pix_en_q;

    // Stage 0: window hit test and row*20+col address. Unsigned 10-bit
    // subtraction makes coordinates left of / above the window wrap high.
    always_comb begin
        col_d  = bus.i_x - X0_V;
        row_d  = bus.i_y - Y0_V;
        show_d = (state_q == ST_SHOW3) || (state_q == ST_SHOW2) ||
                 (state_q == ST_SHOW1);
        hit_d  = show_d && bus.i_active && (col_d < SPR_SZ) && (row_d < SPR_SZ);
        addr_d = '0;
        if (hit_d) begin
            addr_d = (row_d << 4) + (row_d << 2) + col_d;
        end
    end

    // Sequencer: digit advances only on frame ticks, which arrive in blanking,
    // so a digit never changes mid-frame.
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            digit_q <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        state_q <= ST_SHOW3;
                        cnt_q   <= '0;
                        digit_q <= 2'd3;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHOW3, ST_SHOW2, ST_SHOW1: begin
                    if (bus.i_frame_tick) begin
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            case (state_q)
                                ST_SHOW3: begin
                                    state_q <= ST_SHOW2;
                                    digit_q <= 2'd2;
                                end
                                ST_SHOW2: begin
                                    state_q <= ST_SHOW1;
                                    digit_q <= 2'd1;
                                end
                                default: begin
                                    state_q <= ST_DONE;
                                    digit_q <= 2'd0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    digit_q <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel pipeline: hit flag rides two stages beside the ROM read so it
    // lines up with i_romdata; transparent KEY pixels are never enabled.
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            addr_q   <= '0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            pix_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            hit1_q   <= hit_d;
            hit2_q   <= hit1_q;
            pix_q    <= bus.i_romdata;
            pix_en_q <= hit2_q && (bus.i_romdata != KEY);
        end
    end

    assign bus.o_numberaddr = addr_q;
    assign bus.o_digit      = digit_q;
    assign bus.o_pix        = pix_q;
    assign bus.o_pix_en     = pix_en_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_state      = state_q;
endmodule
